// File: rtl/wb_slave_mux_pkg.sv
// Shared constants and helpers for the Wishbone single-master slave mux.
package wb_slave_mux_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    // Slave index width; a single slave still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/wb_slave_mux_if.sv
// Bus bundle joining the Wishbone master, the slave mux and its N slaves.
interface wb_slave_mux_if #(
    parameter int N_SLAVES = 4,
    parameter int AW       = 32,
    parameter int DW       = 32
);
    // A request is taken when cyc & stb are high and stall is low; ack or err
    // then marks completion for exactly one cycle while cyc is still held.
    logic                   i_wb_cyc;
    logic                   i_wb_stb;
    logic                   i_wb_we;
    logic [AW-1:0]          i_wb_addr;
    logic [DW-1:0]          i_wb_data;
    logic [DW/8-1:0]        i_wb_sel;
    logic                   o_wb_stall;
    logic                   o_wb_ack;
    logic                   o_wb_err;
    logic [DW-1:0]          o_wb_data;
    logic [N_SLAVES-1:0]    o_s_cyc;
    logic [N_SLAVES-1:0]    o_s_stb;
    logic                   o_s_we;
    logic [AW-1:0]          o_s_addr;
    logic [DW-1:0]          o_s_data;
    logic [DW/8-1:0]        o_s_sel;
    logic [N_SLAVES-1:0]    i_s_stall;
    logic [N_SLAVES-1:0]    i_s_ack;
    logic [N_SLAVES*DW-1:0] i_s_data;

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        input  i_s_stall, i_s_ack, i_s_data,
        output o_wb_stall, o_wb_ack, o_wb_err, o_wb_data,
        output o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel
    );

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        output i_s_stall, i_s_ack, i_s_data,
        input  o_wb_stall, o_wb_ack, o_wb_err, o_wb_data,
        input  o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel
    );

endinterface

// File: rtl/wb_addr_decode.sv
// Combinational base/mask address decoder; the lowest matching slave index wins.
module wb_addr_decode #(
    parameter int                       N_SLAVES   = 4,
    parameter int                       AW         = 32,
    parameter int                       IW         = 2,
    parameter logic [N_SLAVES*AW-1:0]   SLAVE_BASE = '0,
    parameter logic [N_SLAVES*AW-1:0]   SLAVE_MASK = '0
) (
    input  logic [AW-1:0] addr,
    output logic          hit,
    output logic [IW-1:0] index,
    output logic [AW-1:0] offset
);

    // Scan from the top so that a lower-indexed match overwrites a higher one.
    always_comb begin
        hit    = 1'b0;
        index  = '0;
        offset = addr;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((addr & SLAVE_MASK[i*AW +: AW]) == SLAVE_BASE[i*AW +: AW]) begin
                hit    = 1'b1;
                index  = IW'(i);
                offset = addr & ~SLAVE_MASK[i*AW +: AW];
            end
        end
    end

endmodule

// File: rtl/wb_slave_mux.sv
// Single-master Wishbone interconnect: decodes, forwards one transaction at a
// time to the selected slave, and returns ack, or err for unmapped/timeout.
module wb_slave_mux
    import wb_slave_mux_pkg::*;
#(
    parameter int                     N_SLAVES   = 4,
    parameter int                     AW         = 32,
    parameter int                     DW         = 32,
    parameter logic [N_SLAVES*AW-1:0] SLAVE_BASE = '0,
    parameter logic [N_SLAVES*AW-1:0] SLAVE_MASK = '0,
    parameter int                     TIMEOUT    = 255,
    parameter logic [DW-1:0]          ERR_DATA   = DW'(ERR_DATA_DEFAULT)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    wb_slave_mux_if.slave     bus,
    output logic [7:0]        o_err_cnt,
    output logic [1:0]        dbg_state
);

    localparam int          IW        = idx_width(N_SLAVES);
    localparam int          SW        = DW / 8;
    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT);

    logic [1:0]          state;
    logic [IW-1:0]       idx;
    logic                resp_err;
    logic [DW-1:0]       rdata;
    logic [31:0]         tmo_cnt;
    logic [7:0]          err_cnt;
    logic                we_r;
    logic [AW-1:0]       addr_r;
    logic [DW-1:0]       data_r;
    logic [SW-1:0]       sel_r;

    logic                dec_hit;
    logic [IW-1:0]       dec_idx;
    logic [AW-1:0]       dec_off;
    logic [N_SLAVES-1:0] sel_vec;
    logic                s_stall;
    logic                s_ack;
    logic [DW-1:0]       s_data;
    logic                timed_out;
    logic                busy;

    wb_addr_decode #(
        .N_SLAVES   (N_SLAVES),
        .AW         (AW),
        .IW         (IW),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .addr   (bus.i_wb_addr),
        .hit    (dec_hit),
        .index  (dec_idx),
        .offset (dec_off)
    );

    assign sel_vec   = N_SLAVES'(1) << idx;
    assign s_stall   = bus.i_s_stall[idx];
    assign s_ack     = bus.i_s_ack[idx];
    assign s_data    = bus.i_s_data[idx*DW +: DW];
    assign busy      = (state == ST_REQ) || (state == ST_WAIT);
    assign timed_out = (TIMEOUT != 0) && (tmo_cnt == TMO_LIMIT);

    assign bus.o_s_cyc    = busy ? sel_vec : '0;
    assign bus.o_s_stb    = (state == ST_REQ) ? sel_vec : '0;
    assign bus.o_s_we     = we_r;
    assign bus.o_s_addr   = addr_r;
    assign bus.o_s_data   = data_r;
    assign bus.o_s_sel    = sel_r;
    assign bus.o_wb_stall = (state != ST_IDLE);
    assign bus.o_wb_ack   = (state == ST_RESP) && !resp_err;
    assign bus.o_wb_err   = (state == ST_RESP) && resp_err;
    assign bus.o_wb_data  = rdata;
    assign o_err_cnt      = err_cnt;
    assign dbg_state      = state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            resp_err <= 1'b0;
            rdata    <= '0;
            tmo_cnt  <= '0;
            err_cnt  <= '0;
            we_r     <= 1'b0;
            addr_r   <= '0;
            data_r   <= '0;
            sel_r    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_wb_cyc && bus.i_wb_stb) begin
                        we_r    <= bus.i_wb_we;
                        addr_r  <= dec_off;
                        data_r  <= bus.i_wb_data;
                        sel_r   <= bus.i_wb_sel;
                        idx     <= dec_idx;
                        tmo_cnt <= '0;
                        if (dec_hit) begin
                            state <= ST_REQ;
                        end else begin
                            state    <= ST_RESP;
                            resp_err <= 1'b1;
                            rdata    <= ERR_DATA;
                            err_cnt  <= sat_inc8(err_cnt);
                        end
                    end
                end
                ST_REQ, ST_WAIT: begin
                    // Abort wins over everything: the master no longer wants a reply.
                    if (!bus.i_wb_cyc) begin
                        state <= ST_IDLE;
                    end else if (s_ack && (state == ST_WAIT || !s_stall)) begin
                        state    <= ST_RESP;
                        resp_err <= 1'b0;
                        rdata    <= s_data;
                    end else if (timed_out) begin
                        state    <= ST_RESP;
                        resp_err <= 1'b1;
                        rdata    <= ERR_DATA;
                        err_cnt  <= sat_inc8(err_cnt);
                    end else begin
                        if (state == ST_REQ && !s_stall) begin
                            state <= ST_WAIT;
                        end
                        if (tmo_cnt != TMO_LIMIT) begin
                            tmo_cnt <= tmo_cnt + 32'd1;
                        end
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_slave_mux.sv
// Directed bench for wb_slave_mux: master driver, slave responder model and a
// response scoreboard that pops one expected {check_data, err, data} per reply.
module tb_wb_slave_mux;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;
    // slave3 .. slave0
    localparam logic [N*AW-1:0] BASE = {32'h0000_2000, 32'h0000_1000, 32'h0000_0800, 32'h0000_1000};
    localparam logic [N*AW-1:0] MASK = {32'h0000_F000, 32'h0000_F800, 32'h0000_F800, 32'h0000_F000};

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] err_cnt;
    logic [1:0] dbg_state;

    wb_slave_mux_if #(.N_SLAVES(N), .AW(AW), .DW(DW)) bus ();

    wb_slave_mux #(
        .N_SLAVES   (N),
        .AW         (AW),
        .DW         (DW),
        .SLAVE_BASE (BASE),
        .SLAVE_MASK (MASK),
        .TIMEOUT    (TMO),
        .ERR_DATA   (32'hDEADBEEF)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .bus       (bus),
        .o_err_cnt (err_cnt),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [33:0] exp_q[$];

    // slave responder configuration
    int          tgt = 0;
    int          stall_left = 0;
    int          ack_delay = 0;
    int          wait_left = 0;
    bit          ack_en = 1'b0;
    logic [N-1:0] spur_ack = '0;

    // expected shared outputs while stb is up
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [3:0]  exp_sel;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave model: stalls, then accepts, then acks after ack_delay cycles.
    always @(negedge clk) begin
        logic [N-1:0] st;
        logic [N-1:0] ak;
        st = '0;
        ak = spur_ack;
        if (bus.o_s_stb[tgt]) begin
            if (stall_left > 0) begin
                st[tgt] = 1'b1;
                stall_left--;
            end else if (ack_en && ack_delay == 0) begin
                ak[tgt] = 1'b1;
            end else begin
                wait_left = ack_delay;
            end
        end else if (bus.o_s_cyc[tgt] && ack_en && wait_left > 0) begin
            wait_left--;
            if (wait_left == 0) ak[tgt] = 1'b1;
        end
        bus.i_s_stall = st;
        bus.i_s_ack   = ak;
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [33:0] e;
        if (!rst && (bus.o_wb_ack || bus.o_wb_err)) begin
            check("ack_err_exclusive", 64'(bus.o_wb_ack & bus.o_wb_err), 64'(0));
            check("resp_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("resp_err", 64'(bus.o_wb_err), 64'(e[32]));
                if (e[33]) check("resp_data", 64'(bus.o_wb_data), 64'(e[31:0]));
            end
        end
    end

    task automatic setup(input int t, input int stalls, input int dly, input bit en,
                         input logic [31:0] rdata, input logic [N-1:0] spur);
        tgt        = t;
        stall_left = stalls;
        ack_delay  = dly;
        wait_left  = 0;
        ack_en     = en;
        spur_ack   = spur;
        for (int i = 0; i < N; i++) bus.i_s_data[i*DW +: DW] = 32'hBAD0_0000 | 32'(i);
        bus.i_s_data[t*DW +: DW] = rdata;
        @(negedge clk);
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] sel);
        bus.i_wb_cyc  = 1'b1;
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_we   = we;
        bus.i_wb_addr = addr;
        bus.i_wb_data = data;
        bus.i_wb_sel  = sel;
        @(negedge clk);
        bus.i_wb_stb  = 1'b0;
    endtask

    // n counts negedges since the request negedge; stops at the response cycle.
    task automatic wait_resp(input int limit, output int n, output int stb_n, output bit ok,
                             output bit any_cyc, output bit other_cyc);
        n = 1; stb_n = 0; ok = 1'b1; any_cyc = 1'b0; other_cyc = 1'b0;
        while (!(bus.o_wb_ack || bus.o_wb_err) && n <= limit) begin
            if (bus.o_s_stb[tgt]) begin
                stb_n++;
                if (bus.o_s_we !== exp_we || bus.o_s_addr !== exp_addr ||
                    bus.o_s_data !== exp_data || bus.o_s_sel !== exp_sel) ok = 1'b0;
            end
            if (|bus.o_s_cyc) any_cyc = 1'b1;
            if ((bus.o_s_cyc & ~(N'(1) << tgt)) != '0) other_cyc = 1'b1;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic end_txn();
        bus.i_wb_cyc = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_s_cyc"},   64'(bus.o_s_cyc),    64'(0));
        check({tag, "_s_stb"},   64'(bus.o_s_stb),    64'(0));
        check({tag, "_ack"},     64'(bus.o_wb_ack),   64'(0));
        check({tag, "_err"},     64'(bus.o_wb_err),   64'(0));
        check({tag, "_stall"},   64'(bus.o_wb_stall), 64'(0));
        check({tag, "_wb_data"}, 64'(bus.o_wb_data),  64'(0));
        check({tag, "_err_cnt"}, 64'(err_cnt),        64'(0));
        check({tag, "_s_shared"}, 64'({bus.o_s_we, bus.o_s_addr, bus.o_s_data, bus.o_s_sel}), 64'(0));
        check({tag, "_state"},   64'(dbg_state),      64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, stb_n;
        bit ok, any_cyc, other_cyc;

        rst = 1'b1;
        bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
        bus.i_wb_addr = '0; bus.i_wb_data = '0; bus.i_wb_sel = '0;
        bus.i_s_stall = '0; bus.i_s_ack = '0; bus.i_s_data = '0;
        repeat (3) @(negedge clk);
        check_reset("rst0");
        rst = 1'b0;
        @(negedge clk);

        // single read with ack in the accept cycle
        setup(1, 0, 0, 1'b1, 32'h1234_5678, '0);
        exp_we = 1'b0; exp_addr = 32'h0000_0004; exp_data = 32'h0; exp_sel = 4'hF;
        exp_q.push_back({1'b1, 1'b0, 32'h1234_5678});
        issue(1'b0, 32'h0000_0804, 32'h0, 4'hF);
        wait_resp(20, n, stb_n, ok, any_cyc, other_cyc);
        check("rd_latency", 64'(n), 64'(2));
        check("rd_stb_cycles", 64'(stb_n), 64'(1));
        check("rd_shared", 64'(ok), 64'(1));
        check("rd_other_cyc", 64'(other_cyc), 64'(0));
        end_txn();

        // write with three stall cycles
        setup(1, 3, 0, 1'b1, 32'h0, '0);
        exp_we = 1'b1; exp_addr = 32'h0000_0010; exp_data = 32'hA5A5_A5A5; exp_sel = 4'b0011;
        exp_q.push_back({1'b0, 1'b0, 32'h0});
        issue(1'b1, 32'h0000_0810, 32'hA5A5_A5A5, 4'b0011);
        wait_resp(20, n, stb_n, ok, any_cyc, other_cyc);
        check("wr_latency", 64'(n), 64'(5));
        check("wr_stb_cycles", 64'(stb_n), 64'(4));
        check("wr_shared_stable", 64'(ok), 64'(1));
        end_txn();

        // unmapped address
        setup(0, 0, 0, 1'b0, 32'h0, '0);
        exp_q.push_back({1'b1, 1'b1, 32'hDEAD_BEEF});
        issue(1'b0, 32'hF000_0000, 32'h0, 4'hF);
        wait_resp(20, n, stb_n, ok, any_cyc, other_cyc);
        check("unmap_latency", 64'(n), 64'(1));
        check("unmap_no_cyc", 64'(any_cyc), 64'(0));
        end_txn();
        check("unmap_err_cnt", 64'(err_cnt), 64'(1));

        // overlapping map picks slave 0; slave 3 acks spuriously throughout
        setup(0, 0, 2, 1'b1, 32'h0000_5A5A, 4'b1000);
        exp_we = 1'b0; exp_addr = 32'h0000_0004; exp_data = 32'h0; exp_sel = 4'hF;
        exp_q.push_back({1'b1, 1'b0, 32'h0000_5A5A});
        issue(1'b0, 32'h0000_1004, 32'h0, 4'hF);
        wait_resp(20, n, stb_n, ok, any_cyc, other_cyc);
        check("ovl_latency", 64'(n), 64'(4));
        check("ovl_other_cyc", 64'(other_cyc), 64'(0));
        check("ovl_shared", 64'(ok), 64'(1));
        end_txn();

        // timeout: slave 3 accepts but never acks
        setup(3, 0, 0, 1'b0, 32'h0, '0);
        exp_we = 1'b0; exp_addr = 32'h0; exp_data = 32'h0; exp_sel = 4'hF;
        exp_q.push_back({1'b1, 1'b1, 32'hDEAD_BEEF});
        issue(1'b0, 32'h0000_2000, 32'h0, 4'hF);
        wait_resp(40, n, stb_n, ok, any_cyc, other_cyc);
        check("tmo_latency", 64'(n), 64'(TMO + 2));
        check("tmo_cyc_dropped", 64'(bus.o_s_cyc), 64'(0));
        end_txn();
        check("tmo_err_cnt", 64'(err_cnt), 64'(2));

        for (int k = 0; k < 298; k++) begin
            exp_q.push_back({1'b1, 1'b1, 32'hDEAD_BEEF});
            issue(1'b0, 32'h0000_2004 + 32'(k), 32'h0, 4'hF);
            wait_resp(40, n, stb_n, ok, any_cyc, other_cyc);
            end_txn();
        end
        check("err_cnt_sat", 64'(err_cnt), 64'(255));

        exp_q.push_back({1'b1, 1'b1, 32'hDEAD_BEEF});
        issue(1'b0, 32'hF000_0000, 32'h0, 4'hF);
        wait_resp(20, n, stb_n, ok, any_cyc, other_cyc);
        end_txn();
        check("err_cnt_hold", 64'(err_cnt), 64'(255));

        // master abort while waiting for ack
        setup(1, 0, 0, 1'b0, 32'h0, '0);
        issue(1'b0, 32'h0000_0820, 32'h0, 4'hF);
        @(negedge clk);
        check("abort_in_wait", 64'(dbg_state), 64'(2));
        bus.i_wb_cyc = 1'b0;
        @(negedge clk);
        check("abort_s_cyc", 64'({bus.o_s_cyc, bus.o_s_stb}), 64'(0));
        check("abort_no_resp", 64'({bus.o_wb_ack, bus.o_wb_err}), 64'(0));
        check("abort_idle", 64'(bus.o_wb_stall), 64'(0));
        repeat (3) @(negedge clk);
        check("abort_err_cnt", 64'(err_cnt), 64'(255));

        // reset in the middle of a wait
        setup(1, 0, 0, 1'b0, 32'h0, '0);
        issue(1'b1, 32'h0000_0830, 32'h1111_2222, 4'hC);
        @(negedge clk);
        check("rst_in_wait", 64'(dbg_state), 64'(2));
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst_mid");
        bus.i_wb_cyc = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
